// File: rtl/ahb_master_sm.sv
// AHB initiator turning (addr, len, dir) commands into word SINGLE/INCR transfers; all outputs registered.
// Address phase n overlaps data phase n-1; HREADY low holds the bus and stalls the command; ERROR aborts it.
module ahb_master_sm #(
    parameter int MAX_BEATS = 16,
    parameter int LEN_W     = 5
) (
    input  logic             HCLOCK,
    input  logic             HRESETn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [31:0]      cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [31:0]      wr_data,
    output logic             wr_pop,
    output logic [31:0]      rd_data,
    output logic             rd_valid,
    output logic             done,
    output logic             err,
    output logic [31:0]      HADDRESS,
    output logic [1:0]       HTRANS,
    output logic             HWRITE,
    output logic [1:0]       HSIZE,
    output logic [2:0]       HBURST,
    output logic [31:0]      HWDATA,
    input  logic             HREADY,
    input  logic [1:0]       HRESP,
    input  logic [31:0]      HRDATA
);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_BURST, S_LAST, S_ERR2} state_t;

    localparam logic [1:0]       TR_IDLE   = 2'b00;
    localparam logic [1:0]       TR_NONSEQ = 2'b10;
    localparam logic [1:0]       TR_SEQ    = 2'b11;
    localparam logic [1:0]       RESP_OKAY = 2'b00;
    localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(MAX_BEATS);
    localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);

    state_t           r_state;
    logic [LEN_W-1:0] r_beats;
    logic [31:0]      r_haddr;
    logic [31:0]      r_hwdata;
    logic [31:0]      r_rd_data;
    logic [1:0]       r_htrans;
    logic [2:0]       r_hburst;
    logic             r_hwrite;
    logic             r_cmd_ready;
    logic             r_wr_pop;
    logic             r_rd_valid;
    logic             r_done;
    logic             r_err;

    logic [LEN_W-1:0] w_len_nz;
    logic [LEN_W-1:0] w_len_load;
    logic [31:0]      w_next_addr;
    logic [1:0]       w_next_trans;
    logic             w_resp_err;
    logic             w_dphase;

    assign w_len_nz     = (cmd_len == '0) ? LEN_ONE : cmd_len;
    assign w_len_load   = (w_len_nz > LEN_MAX) ? LEN_MAX : w_len_nz;
    assign w_next_addr  = r_haddr + 32'd4;
    // A burst may not cross a 1KB boundary, so restart with NONSEQ there.
    assign w_next_trans = (w_next_addr[9:0] == 10'd0) ? TR_NONSEQ : TR_SEQ;
    assign w_resp_err   = (HRESP != RESP_OKAY);
    assign w_dphase     = (r_state == S_BURST);

    always_ff @(posedge HCLOCK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state     <= S_IDLE;
            r_beats     <= '0;
            r_haddr     <= '0;
            r_hwdata    <= '0;
            r_rd_data   <= '0;
            r_htrans    <= TR_IDLE;
            r_hburst    <= 3'b000;
            r_hwrite    <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_wr_pop    <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_wr_pop   <= 1'b0;
            r_rd_valid <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            // The client presents the popped word until the cycle after wr_pop.
            if (r_wr_pop) r_hwdata <= wr_data;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid && r_cmd_ready) begin
                        r_haddr     <= {cmd_addr[31:2], 2'b00};
                        r_htrans    <= TR_NONSEQ;
                        r_hwrite    <= cmd_write;
                        r_hburst    <= (w_len_load == LEN_ONE) ? 3'b000 : 3'b001;
                        r_beats     <= w_len_load;
                        r_cmd_ready <= 1'b0;
                        r_state     <= S_ADDR;
                    end
                end
                S_ADDR, S_BURST: begin
                    if (w_dphase && w_resp_err) begin
                        r_htrans <= TR_IDLE;
                        if (HREADY) begin
                            r_done      <= 1'b1;
                            r_err       <= 1'b1;
                            r_cmd_ready <= 1'b1;
                            r_state     <= S_IDLE;
                        end else begin
                            r_state <= S_ERR2;
                        end
                    end else if (HREADY) begin
                        if (w_dphase && !r_hwrite) begin
                            r_rd_data  <= HRDATA;
                            r_rd_valid <= 1'b1;
                        end
                        r_beats  <= (r_beats != '0) ? r_beats - LEN_ONE : r_beats;
                        r_wr_pop <= r_hwrite;
                        if (r_beats > LEN_ONE) begin
                            r_haddr  <= w_next_addr;
                            r_htrans <= w_next_trans;
                            r_state  <= S_BURST;
                        end else begin
                            r_htrans <= TR_IDLE;
                            r_state  <= S_LAST;
                        end
                    end
                end
                S_LAST: begin
                    if (w_resp_err && !HREADY) begin
                        r_state <= S_ERR2;
                    end else if (HREADY) begin
                        if (!w_resp_err && !r_hwrite) begin
                            r_rd_data  <= HRDATA;
                            r_rd_valid <= 1'b1;
                        end
                        r_done      <= 1'b1;
                        r_err       <= w_resp_err;
                        r_cmd_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                S_ERR2: begin
                    if (HREADY) begin
                        r_done      <= 1'b1;
                        r_err       <= 1'b1;
                        r_cmd_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign wr_pop    = r_wr_pop;
    assign rd_data   = r_rd_data;
    assign rd_valid  = r_rd_valid;
    assign done      = r_done;
    assign err       = r_err;
    assign HADDRESS  = r_haddr;
    assign HTRANS    = r_htrans;
    assign HWRITE    = r_hwrite;
    assign HSIZE     = 2'b10;
    assign HBURST    = r_hburst;
    assign HWDATA    = r_hwdata;

endmodule

// File: tb/tb_ahb_master_sm.sv
// Bench for ahb_master_sm: command table driven through a small AHB slave model with scoreboard queues.
module tb_ahb_master_sm;

    logic        HCLOCK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [4:0]  cmd_len;
    logic [31:0] wr_data, rd_data;
    logic        wr_pop, rd_valid, done, err;
    logic [31:0] HADDRESS, HWDATA, HRDATA;
    logic [1:0]  HTRANS, HSIZE, HRESP;
    logic        HWRITE, HREADY;
    logic [2:0]  HBURST;

    ahb_master_sm #(.MAX_BEATS(16), .LEN_W(5)) dut (
        .HCLOCK(HCLOCK), .HRESETn(HRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_pop(wr_pop),
        .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err(err),
        .HADDRESS(HADDRESS), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HWDATA(HWDATA),
        .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
    );

    always #5 HCLOCK = ~HCLOCK;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [4:0]  len;
        int          waits;     // wait states per data phase
        int          err_beat;  // beat whose data phase gets ERROR, 0 = none
        int          exp_n;     // expected beat count after clamping
        logic        exp_err;
    } cmd_vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    logic [39:0] q_addr[$];
    logic [31:0] q_rd[$];
    logic [31:0] q_wd[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event missing or unexpected", name);
    endtask

    function automatic logic [31:0] wword(input int i);
        return 32'hDEADBEEF + 32'h01010101 * 32'(i);
    endfunction

    function automatic logic [31:0] rword(input logic [31:0] a);
        return 32'h12345634 + a;
    endfunction

    task automatic check_reset_outputs(input string name);
        check({name, "_bus"}, {HTRANS, HADDRESS, HWRITE, HSIZE, HBURST}, {2'b00, 32'h0, 1'b0, 2'b10, 3'b000});
        check({name, "_hwdata"}, HWDATA, 32'h0);
        check({name, "_client"}, {cmd_ready, wr_pop, rd_valid, rd_data, done, err}, {1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0});
    endtask

    // Issues one command at the current negedge and runs the slave model until done.
    task automatic run_cmd(input cmd_vec_t v);
        int          n_acc_exp, exp_pops, exp_rds, pops, rds, n_acc, widx;
        int          dp_waits, dp_beat, err_stage;
        bit          got_done, pop_last, dp_act, prev_wait, err_last;
        logic [31:0] base, a, dp_addr, prev_addr;
        logic [1:0]  prev_trans;

        base      = {v.addr[31:2], 2'b00};
        n_acc_exp = (v.err_beat != 0) ? v.err_beat : v.exp_n;
        exp_pops  = v.wr ? n_acc_exp : 0;
        exp_rds   = v.wr ? 0 : ((v.err_beat != 0) ? v.err_beat - 1 : v.exp_n);
        for (int i = 0; i < n_acc_exp; i++) begin
            a = base + 32'(4 * i);
            q_addr.push_back({a, (i == 0 || a[9:0] == 10'd0) ? 2'b10 : 2'b11,
                              (v.exp_n == 1) ? 3'b000 : 3'b001, v.wr, 2'b10});
            if (v.wr) q_wd.push_back(wword(i));
        end
        for (int i = 0; i < exp_rds; i++) q_rd.push_back(rword(base + 32'(4 * i)));

        cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_len = v.len;
        widx = 0; wr_data = wword(0);
        HREADY = 1'b1; HRESP = 2'b00; HRDATA = 32'h0;
        pops = 0; rds = 0; n_acc = 0; got_done = 0; pop_last = 0; dp_act = 0;
        prev_wait = 0; err_last = 0; dp_waits = 0; dp_beat = 0; err_stage = 0;
        dp_addr = 32'h0; prev_addr = 32'h0; prev_trans = 2'b00;

        for (int cyc = 0; cyc < 300 && !got_done; cyc++) begin
            @(negedge HCLOCK);
            if (!cmd_ready) cmd_valid = 1'b0;
            if (pop_last) begin
                if (q_wd.size() == 0) fail_now("hwdata_extra");
                else check("hwdata", HWDATA, q_wd.pop_front());
                widx++;
                wr_data = wword(widx);
            end
            pop_last = wr_pop;
            if (wr_pop) pops++;
            if (rd_valid) begin
                rds++;
                if (q_rd.size() == 0) fail_now("rd_valid_extra");
                else check("rd_data", rd_data, q_rd.pop_front());
            end
            if (prev_wait) check("hold_addr_trans", {HADDRESS, HTRANS}, {prev_addr, prev_trans});
            if (err_last) check("htrans_idle_after_error", HTRANS, 2'b00);
            if (done) begin
                got_done = 1;
                check("done_err", err, v.exp_err);
                check("cmd_ready_at_done", cmd_ready, 1'b1);
            end else begin
                HREADY = 1'b1; HRESP = 2'b00; HRDATA = 32'h0;
                if (dp_act) begin
                    if (dp_waits > 0) begin
                        HREADY = 1'b0;
                        dp_waits--;
                    end else if (dp_beat == v.err_beat) begin
                        HRESP = 2'b01;
                        if (err_stage == 0) begin
                            HREADY = 1'b0;
                            err_stage = 1;
                        end else begin
                            dp_act = 0;
                        end
                    end else begin
                        HRDATA = rword(dp_addr);
                        dp_act = 0;
                    end
                end
                if (HREADY && HTRANS[1]) begin
                    n_acc++;
                    if (q_addr.size() == 0) fail_now("addr_phase_extra");
                    else check("addr_phase", {HADDRESS, HTRANS, HBURST, HWRITE, HSIZE}, q_addr.pop_front());
                    dp_act = 1; dp_addr = HADDRESS; dp_beat = n_acc;
                    dp_waits = v.waits; err_stage = 0;
                end
                prev_wait  = !HREADY && (HRESP == 2'b00);
                err_last   = !HREADY && (HRESP != 2'b00);
                prev_addr  = HADDRESS;
                prev_trans = HTRANS;
            end
        end
        if (!got_done) fail_now("done_timeout");
        check("wr_pop_count", 64'(pops), 64'(exp_pops));
        check("rd_valid_count", 64'(rds), 64'(exp_rds));
        check("queues_drained", 64'(q_addr.size() + q_wd.size() + q_rd.size()), 64'd0);
        q_addr.delete(); q_wd.delete(); q_rd.delete();
        cmd_valid = 1'b0; HREADY = 1'b1; HRESP = 2'b00;
    endtask

    cmd_vec_t vecs[9];
    cmd_vec_t v1;
    int       acc;
    bit       found;

    initial begin
        vecs[0] = '{1'b1, 32'h0000_0010, 5'd1,  0, 0, 1,  1'b0};
        vecs[1] = '{1'b0, 32'h0000_0044, 5'd1,  1, 0, 1,  1'b0};
        vecs[2] = '{1'b1, 32'h0000_03F8, 5'd4,  0, 0, 4,  1'b0};
        vecs[3] = '{1'b0, 32'h0000_0100, 5'd0,  0, 0, 1,  1'b0};
        vecs[4] = '{1'b0, 32'h0000_0200, 5'd20, 0, 0, 16, 1'b0};
        vecs[5] = '{1'b1, 32'h0000_0020, 5'd4,  0, 2, 4,  1'b1};
        vecs[6] = '{1'b0, 32'h0000_07F0, 5'd8,  2, 0, 8,  1'b0};
        vecs[7] = '{1'b0, 32'h0000_1003, 5'd3,  0, 3, 3,  1'b1};
        vecs[8] = '{1'b1, 32'h0000_0000, 5'd16, 1, 0, 16, 1'b0};

        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_len = 5'd0;
        wr_data = 32'h0; HREADY = 1'b1; HRESP = 2'b00; HRDATA = 32'h0;
        repeat (3) @(negedge HCLOCK);
        check_reset_outputs("reset");
        HRESETn = 1'b1;
        @(negedge HCLOCK);

        // Each command starts at the negedge where the previous done was seen.
        for (int i = 0; i < 9; i++) run_cmd(vecs[i]);

        // Reset asserted while beat 3 of an 8-beat read is on the bus.
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h500; cmd_len = 5'd8;
        HREADY = 1'b1; HRESP = 2'b00; HRDATA = 32'hA5A5_A5A5;
        acc = 0; found = 0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge HCLOCK);
            if (!cmd_ready) cmd_valid = 1'b0;
            if (acc == 2 && HTRANS[1]) found = 1;
            else if (HTRANS[1]) acc++;
        end
        if (!found) fail_now("beat3_timeout");
        check("beat3_addr", HADDRESS, 32'h508);
        HRESETn = 1'b0;
        cmd_valid = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        repeat (2) @(negedge HCLOCK);
        check("no_done_in_reset", {done, rd_valid}, 2'b00);
        HRESETn = 1'b1;
        v1 = '{1'b0, 32'h0000_0060, 5'd1, 0, 0, 1, 1'b0};
        run_cmd(v1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
